// File: rtl/scr1_dmem_wb_bridge.sv
// SCR1 data-memory port to single-outstanding classic Wishbone B4 master, with lane steering.
// Define SCR1_WB_BRIDGE_TIMEOUT_EN to abort WB cycles that wait TIMEOUT_CYCLES without ack/err.
module scr1_dmem_wb_bridge #(
    parameter int AW             = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n_i,
    input  logic          core2dmem_req_i,
    input  logic          core2dmem_cmd_i,
    input  logic [1:0]    core2dmem_width_i,
    input  logic [AW-1:0] core2dmem_addr_i,
    input  logic [31:0]   core2dmem_wdata_i,
    output logic          dmem2core_req_ack_o,
    output logic [31:0]   dmem2core_rdata_o,
    output logic [1:0]    dmem2core_resp_o,
    output logic [AW-1:0] wbm_adr_o,
    output logic [31:0]   wbm_dat_o,
    input  logic [31:0]   wbm_dat_i,
    output logic          wbm_we_o,
    output logic [3:0]    wbm_sel_o,
    output logic          wbm_stb_o,
    output logic          wbm_cyc_o,
    input  logic          wbm_ack_i,
    input  logic          wbm_err_i,
    output logic          busy_o
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUS = 2'd1, ST_RESP = 2'd2} state_e;

    localparam logic [1:0] RESP_NOTRDY = 2'd0;
    localparam logic [1:0] RESP_OK     = 2'd1;
    localparam logic [1:0] RESP_ER     = 2'd2;
    localparam logic [1:0] WIDTH_BYTE  = 2'd0;
    localparam logic [1:0] WIDTH_HWORD = 2'd1;
    localparam logic [1:0] WIDTH_WORD  = 2'd2;

    function automatic logic [3:0] sel_gen(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE:  sel_gen = 4'b0001 << off;
            WIDTH_HWORD: sel_gen = 4'b0011 << off;
            default:     sel_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE:  misaligned = 1'b0;
            WIDTH_HWORD: misaligned = off[0];
            WIDTH_WORD:  misaligned = (off != 2'b00);
            default:     misaligned = 1'b1;
        endcase
    endfunction

    // Upper bytes are zeroed; the core performs sign extension itself.
    function automatic logic [31:0] rd_steer(input logic [31:0] dat, input logic [1:0] width,
                                             input logic [1:0] off);
        logic [31:0] sh;
        sh = dat >> {off, 3'b000};
        case (width)
            WIDTH_BYTE:  rd_steer = {24'h000000, sh[7:0]};
            WIDTH_HWORD: rd_steer = {16'h0000, sh[15:0]};
            default:     rd_steer = sh;
        endcase
    endfunction

    state_e        state_q, state_d;
    logic          cyc_q, cyc_d, we_q, we_d, busy_q, busy_d;
    logic [AW-1:0] adr_q, adr_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   dat_q, dat_d, rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d, off_q, off_d, width_q, width_d;
`ifdef SCR1_WB_BRIDGE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire_s;
    assign expire_s = (({1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1}) >= (CNT_W + 1)'(TIMEOUT_CYCLES));
`endif

    // Next-state and registered-output computation.
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        sel_d   = sel_q;
        dat_d   = dat_q;
        rdata_d = rdata_q;
        resp_d  = RESP_NOTRDY;
        off_d   = off_q;
        width_d = width_q;
`ifdef SCR1_WB_BRIDGE_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (core2dmem_req_i) begin
                    off_d   = core2dmem_addr_i[1:0];
                    width_d = core2dmem_width_i;
                    if (misaligned(core2dmem_width_i, core2dmem_addr_i[1:0])) begin
                        resp_d  = RESP_ER;
                        state_d = ST_RESP;
                    end else begin
                        cyc_d   = 1'b1;
                        we_d    = core2dmem_cmd_i;
                        adr_d   = {core2dmem_addr_i[AW-1:2], 2'b00};
                        sel_d   = sel_gen(core2dmem_width_i, core2dmem_addr_i[1:0]);
                        dat_d   = core2dmem_cmd_i ?
                                  (core2dmem_wdata_i << {core2dmem_addr_i[1:0], 3'b000}) : 32'h0;
                        state_d = ST_BUS;
`ifdef SCR1_WB_BRIDGE_TIMEOUT_EN
                        cnt_d   = {CNT_W{1'b0}};
`endif
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                if (wbm_err_i || wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    adr_d   = {AW{1'b0}};
                    sel_d   = 4'b0000;
                    dat_d   = 32'h0;
                    state_d = ST_RESP;
                    if (wbm_err_i) begin
                        resp_d  = RESP_ER;
                        rdata_d = 32'h0;
                    end else begin
                        resp_d  = RESP_OK;
                        rdata_d = we_q ? rdata_q : rd_steer(wbm_dat_i, width_q, off_q);
                    end
                end else begin
`ifdef SCR1_WB_BRIDGE_TIMEOUT_EN
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                    if (expire_s) begin
                        cyc_d   = 1'b0;
                        we_d    = 1'b0;
                        adr_d   = {AW{1'b0}};
                        sel_d   = 4'b0000;
                        dat_d   = 32'h0;
                        resp_d  = RESP_ER;
                        rdata_d = 32'h0;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUS;
                    end
`else
                    state_d = ST_BUS;
`endif
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; async reset aborts any WB cycle immediately.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= ST_IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= {AW{1'b0}};
            sel_q   <= 4'b0000;
            dat_q   <= 32'h0;
            rdata_q <= 32'h0;
            resp_q  <= RESP_NOTRDY;
            off_q   <= 2'b00;
            width_q <= 2'b00;
            busy_q  <= 1'b0;
`ifdef SCR1_WB_BRIDGE_TIMEOUT_EN
            cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            dat_q   <= dat_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            off_q   <= off_d;
            width_q <= width_d;
            busy_q  <= busy_d;
`ifdef SCR1_WB_BRIDGE_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign dmem2core_req_ack_o = (state_q == ST_IDLE) && wb_rst_n_i;
    assign dmem2core_rdata_o   = rdata_q;
    assign dmem2core_resp_o    = resp_q;
    assign wbm_adr_o           = adr_q;
    assign wbm_dat_o           = dat_q;
    assign wbm_we_o            = we_q;
    assign wbm_sel_o           = sel_q;
    assign wbm_stb_o           = cyc_q;
    assign wbm_cyc_o           = cyc_q;
    assign busy_o              = busy_q;
endmodule

// File: tb/tb_scr1_dmem_wb_bridge.sv
// Scoreboard bench for scr1_dmem_wb_bridge: random requests, reactive WB slave, byte-level model.
module tb_scr1_dmem_wb_bridge;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0, cmd = 1'b0;
    logic [1:0]    width = 2'd0;
    logic [AW-1:0] addr = '0;
    logic [31:0]   wdata = 32'h0, wb_di = 32'h0;
    logic          req_ack, we_o, stb_o, cyc_o, busy;
    logic [31:0]   rdata, dat_o;
    logic [1:0]    resp;
    logic [AW-1:0] adr_o;
    logic [3:0]    sel_o;
    logic          ack = 1'b0, err = 1'b0;

    scr1_dmem_wb_bridge #(.AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .core2dmem_req_i(req), .core2dmem_cmd_i(cmd), .core2dmem_width_i(width),
        .core2dmem_addr_i(addr), .core2dmem_wdata_i(wdata),
        .dmem2core_req_ack_o(req_ack), .dmem2core_rdata_o(rdata), .dmem2core_resp_o(resp),
        .wbm_adr_o(adr_o), .wbm_dat_o(dat_o), .wbm_dat_i(wb_di), .wbm_we_o(we_o),
        .wbm_sel_o(sel_o), .wbm_stb_o(stb_o), .wbm_cyc_o(cyc_o),
        .wbm_ack_i(ack), .wbm_err_i(err), .busy_o(busy)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        bit          chk_rdata;
        int          due;
    } rsp_t;
    typedef struct {
        logic [AW-1:0] adr;
        logic [3:0]    sel;
        logic [31:0]   dat;
        bit            we;
        int            lat;
        bit            ack;
        bit            err;
        logic [31:0]   di;
    } wb_t;

    rsp_t        rsp_q[$];
    wb_t         wb_q[$];
    int          n_cmp = 0, n_fail = 0;
    logic [31:0] model_rdata = 32'h0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: byte lanes are reasoned about individually.
    task automatic issue(input bit w, input logic [1:0] wd, input logic [31:0] a,
                         input logic [31:0] wv, input int lat, input bit s_ack, input bit s_err,
                         input logic [31:0] di);
        int nb, off, n;
        bit mis;
        wb_t x;
        rsp_t r;
        off = int'(a[1:0]);
        nb  = 1 << wd;
        mis = (wd == 2'd3) || ((off % nb) != 0);
        x.adr = {a[31:2], 2'b00};
        x.sel = 4'b0000;
        x.dat = 32'h0;
        x.we = w; x.lat = lat; x.ack = s_ack; x.err = s_err; x.di = di;
        for (int k = 0; k < 4; k++) if (k >= off && k < off + nb) x.sel[k] = 1'b1;
        for (int j = 0; j < 4; j++) if (w && j >= off) x.dat[8*j +: 8] = wv[8*(j-off) +: 8];
        r.chk_rdata = 1'b1;
        r.rdata = model_rdata;
        if (mis) begin
            r.resp = 2'd2;
            r.chk_rdata = 1'b0;
        end else if (s_err) begin
            r.resp = 2'd2;
            r.rdata = 32'h0;
        end else begin
            r.resp = 2'd1;
            if (!w) begin
                r.rdata = 32'h0;
                for (int k = 0; k < nb; k++) r.rdata[8*k +: 8] = di[8*(off+k) +: 8];
            end
        end
        @(negedge clk);
        req = 1'b1; cmd = w; width = wd; addr = a; wdata = wv;
        n = 0;
        while (!req_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            chk("req_ack_timeout", 64'd0, 64'd1);
            req = 1'b0;
            return;
        end
        r.due = mis ? cyc_cnt + 1 : cyc_cnt + 2 + lat;
        model_rdata = r.rdata;
        rsp_q.push_back(r);
        if (!mis) wb_q.push_back(x);
        @(posedge clk);
        #1;
        req = 1'b0; addr = $urandom; wdata = $urandom; width = 2'($urandom_range(3));
    endtask

    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || wb_q.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 64'd0, 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // WB slave: checks each new cycle against the model and answers after the chosen wait.
    initial begin
        int  s_wait;
        bit  s_active, s_term;
        wb_t cur;
        s_wait = 0; s_active = 0; s_term = 0;
        cur = '{default: '0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0; err = 1'b0; s_active = 0; s_term = 0;
            end else if (cyc_o) begin
                if (s_term) begin
                    chk("cyc_drop_after_term", 64'd1, 64'd0);
                    s_term = 0;
                end else if (!s_active) begin
                    if (wb_q.size() == 0) begin
                        chk("unexpected_cyc", 64'd1, 64'd0);
                        cur = '{adr: adr_o, sel: sel_o, dat: dat_o, we: we_o, lat: 0,
                                ack: 1'b1, err: 1'b0, di: 32'h0};
                    end else begin
                        cur = wb_q.pop_front();
                        chk("wb_adr", 64'(adr_o), 64'(cur.adr));
                        chk("wb_sel", 64'(sel_o), 64'(cur.sel));
                        chk("wb_dat", 64'(dat_o), 64'(cur.dat));
                        chk("wb_we_stb", {62'd0, we_o, stb_o}, {62'd0, cur.we, 1'b1});
                    end
                    s_active = 1; s_wait = cur.lat;
                end else begin
                    chk("wb_hold", {adr_o, sel_o, we_o, stb_o}, {cur.adr, cur.sel, cur.we, 1'b1});
                    chk("wb_hold_dat", 64'(dat_o), 64'(cur.dat));
                end
                if (s_active && !s_term) begin
                    if (s_wait == 0) begin
                        ack = cur.ack; err = cur.err; wb_di = cur.di; s_term = 1;
                    end else begin
                        ack = 1'b0; err = 1'b0; wb_di = $urandom; s_wait--;
                    end
                end
            end else begin
                if (s_active && !s_term) chk("cyc_early_drop", 64'd0, 64'd1);
                s_active = 0; s_term = 0;
                ack = ($urandom_range(7) == 0);
                err = ($urandom_range(15) == 0);
                wb_di = $urandom;
            end
        end
    end

    // Response monitor: pops one expectation per response cycle.
    initial begin
        bit   busy_chk;
        rsp_t e;
        busy_chk = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busy_chk = 0;
            end else begin
                if (busy_chk) begin
                    chk("busy_after_resp", 64'(busy), 64'd0);
                    busy_chk = 0;
                end
                if (resp != 2'd0) begin
                    if (rsp_q.size() == 0) begin
                        chk("unexpected_resp", 64'(resp), 64'd0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("resp", 64'(resp), 64'(e.resp));
                        if (e.chk_rdata) chk("rdata", 64'(rdata), 64'(e.rdata));
                        chk("resp_cycle", 64'(cyc_cnt), 64'(e.due));
                        chk("busy_in_resp", 64'(busy), 64'd1);
                        busy_chk = 1;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wb", {adr_o, sel_o, we_o, stb_o, cyc_o}, 39'd0);
        chk("rst_dat", 64'(dat_o), 64'd0);
        chk("rst_core", {rdata, resp, req_ack, busy}, 36'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("req_ack_idle", 64'(req_ack), 64'd1);

        issue(1'b0, 2'd2, 32'h100, 32'h0,        0, 1'b1, 1'b0, 32'hDEADBEEF);
        issue(1'b1, 2'd0, 32'h203, 32'h000000A5, 1, 1'b1, 1'b0, 32'h0);
        issue(1'b0, 2'd1, 32'h302, 32'h0,        2, 1'b1, 1'b0, 32'h1234ABCD);
        issue(1'b0, 2'd1, 32'h301, 32'h0,        0, 1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd2, 32'h400, 32'hCAFEF00D, 3, 1'b0, 1'b1, 32'h0);
        issue(1'b0, 2'd0, 32'h501, 32'h0,        0, 1'b1, 1'b0, 32'h89ABCDEF);
        issue(1'b0, 2'd2, 32'h600, 32'h0,        1, 1'b1, 1'b1, 32'h55555555);
        issue(1'b1, 2'd3, 32'h700, 32'h12345678, 0, 1'b1, 1'b0, 32'h0);
        issue(1'b1, 2'd1, 32'h802, 32'h87654321, 0, 1'b1, 1'b0, 32'h0);
        drain();

        for (int i = 0; i < 150; i++) begin
            int k;
            k = $urandom_range(9);
            issue(1'($urandom_range(1)), 2'($urandom_range(3)), $urandom & 32'h0000FFFF,
                  $urandom, $urandom_range(4), (k != 0), (k <= 1), $urandom);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();

        issue(1'b0, 2'd2, 32'h900, 32'h0, 30, 1'b1, 1'b0, 32'h11111111);
        repeat (3) @(negedge clk);
        chk("cyc_before_rst", 64'(cyc_o), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_bus", {cyc_o, stb_o, resp, busy, req_ack}, 6'd0);
        rsp_q.delete();
        wb_q.delete();
        model_rdata = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        issue(1'b0, 2'd0, 32'hA02, 32'h0, 1, 1'b1, 1'b0, 32'h00C30000);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
